mm_lsu: RTL and testbench
=========================

Name: mm_lsu

Overview:
- Parametrised successor to the combinational MEM stage. Registered load/store unit between EX/MEM and MEM/WB.
- Drives the memory-controller (mct) handshake through a small FSM and stalls the pipeline while a transaction is outstanding.
- Adds unsigned loads, misalignment and illegal-size detection, a transaction timeout, and a registered writeback output.

Parameters:
XLEN, 32, data/address width
RAW, 5, register-address width
TMO, 255, cycles to wait for mct_ok before aborting; 0 disables the timeout
TW, $clog2(TMO+1) (min 1), timeout counter width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
we  in  1  writeback enable from EX/MEM
wa  in  RAW  writeback register address
wn  in  XLEN  ALU result: effective address for memory ops, otherwise writeback data
mem_v  in  1  memory op valid
mem_wr  in  1  1 = store, 0 = load
mem_sz  in  2  access size: 0 byte, 1 half, 3 word; 2 reserved
mem_us  in  1  unsigned load (zero-extend)
mem_n  in  XLEN  store data, lane-0 aligned
we_o  out  1  registered writeback enable
wa_o  out  RAW  registered writeback address
wn_o  out  XLEN  registered writeback data
mct_a  out  XLEN  controller address
mct_n_i  out  XLEN  controller write data
mct_n_o  in  XLEN  controller read data, lane-0 aligned
mct_wr  out  1  controller write strobe qualifier
mct_e  out  1  controller request enable
mct_cu  out  2  controller access size, same encoding as mem_sz
mct_ok  in  1  controller completion, one-cycle pulse
stl  out  1  stall to upstream stages (combinational)
err  out  1  one-cycle pulse on misaligned, illegal-size or timed-out access

Behaviour:
- Reset (async, rst=1):
  - All registered outputs clear to 0: we_o, wa_o, wn_o, mct_a, mct_n_i, mct_wr, mct_e, mct_cu, err.
  - FSM goes to IDLE; timeout counter clears.
  - Reset mid-transaction drops mct_e immediately. The controller must treat the loss of mct_e as an abort.
- FSM states: IDLE, BUSY.
- IDLE, mem_v=0:
  - Pass-through with 1-cycle latency: we_o<=we, wa_o<=wa, wn_o<=wn.
  - stl=0.
- IDLE, mem_v=1, illegal:
  - Illegal means mem_sz=2, or half access with wn[0]=1, or word access with wn[1:0]!=0.
  - No mct request. we_o<=0. err<=1 for one cycle. stl=0.
- IDLE, mem_v=1, legal:
  - Latch into registers: mct_a<=wn, mct_cu<=mem_sz, mct_wr<=mem_wr, mct_n_i<=mem_n (stores only), wa, we, mem_us.
  - Set mct_e<=1, we_o<=0, clear the counter, go to BUSY.
  - stl=1 this cycle.
- BUSY, mct_ok=0:
  - Hold all mct outputs stable; counter increments; stl=1.
  - If TMO!=0 and counter reaches TMO-1: mct_e<=0, we_o<=0, err<=1, go to IDLE.
- BUSY, mct_ok=1:
  - mct_e<=0; go to IDLE; stl=0 so the upstream instruction advances next edge.
  - Load: we_o<=latched we, wa_o<=latched wa, wn_o<=extend(mct_n_o).
  - Store: we_o<=0.
- Extension rules:
  - Byte: bits [7:0]; upper bits are bit 7 (signed) or 0 (unsigned).
  - Half: bits [15:0]; upper bits are bit 15 (signed) or 0 (unsigned).
  - Word: passed unchanged. mem_us is ignored for word.
- Latency: a load with mct_ok arriving N cycles after mct_e rises gives wn_o valid N+1 cycles after the request cycle.
- Inputs are ignored in BUSY. Upstream must hold them under stl.
- mct_ok in IDLE is ignored.
- mct_ok on the same cycle the timeout fires: completion wins and err stays 0.
- err is never asserted together with we_o=1.

Decomposition:
- Shared package holds:
  - Size encoding constants SZ_B=0, SZ_H=1, SZ_W=3.
  - FSM state typedef {IDLE, BUSY}.
  - Function is_misaligned(sz, addr).
- One natural sub-module, mm_ext: combinational load extender (XLEN, size, unsigned) -> XLEN.

Test Plan:
- Pass-through: mem_v=0, we=1, wa=5'd7, wn=32'h1234 -> next cycle we_o=1, wa_o=7, wn_o=32'h1234; stl=0 throughout.
- Signed byte load: addr 32'h100, mem_sz=0, mem_us=0, mct_ok after 3 cycles with mct_n_o=32'h000000F0 -> stl high for 3 cycles, then wn_o=32'hFFFFFFF0, we_o=1.
- Unsigned half load: mem_sz=1, mem_us=1, mct_n_o=32'hABCD8001 -> wn_o=32'h00008001.
- Store word: addr 32'h200, mem_n=32'hDEADBEEF, mem_wr=1 -> mct_a=32'h200, mct_n_i=32'hDEADBEEF, mct_wr=1, mct_cu=3, all held until mct_ok; we_o=0 afterwards.
- Misaligned/illegal: word access at 32'h202, then mem_sz=2 at 32'h0 -> mct_e stays 0, err pulses one cycle each, we_o=0.
- Timeout and reset: TMO=4, no mct_ok -> err after 4 BUSY cycles and mct_e drops. Separately, assert rst in the 2nd BUSY cycle -> mct_e=0 and stl=0 immediately; after release the FSM is in IDLE.

Source files
------------

// File: rtl/mm_lsu_pkg.sv
// Shared definitions for the mm_lsu load/store unit: access-size encoding,
// FSM state type and the alignment/legality helpers.
package mm_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;  // byte
  localparam logic [1:0] SZ_H = 2'd1;  // half word
  localparam logic [1:0] SZ_R = 2'd2;  // reserved encoding, always illegal
  localparam logic [1:0] SZ_W = 2'd3;  // word

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Only the two low address bits matter for alignment of byte/half/word.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic r;
    case (sz)
      SZ_H:    r = addr_lo[0];
      SZ_W:    r = (addr_lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] addr_lo);
    return (sz == SZ_R) || is_misaligned(sz, addr_lo);
  endfunction

endpackage

// File: rtl/mm_lsu_ext.sv
// Combinational load extender: selects the lane-0 byte/half/word of the
// controller read data and sign- or zero-extends it to XLEN.
module mm_ext #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] din,
  input  logic [1:0]      sz,
  input  logic            us,
  output logic [XLEN-1:0] dout
);
  import mm_lsu_pkg::*;

  // Fill bit is the top bit of the accessed lane unless the load is unsigned.
  always_comb begin
    dout = din;
    case (sz)
      SZ_B:    dout = {{(XLEN-8){us ? 1'b0 : din[7]}}, din[7:0]};
      SZ_H:    dout = {{(XLEN-16){us ? 1'b0 : din[15]}}, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/mm_lsu.sv
// Registered load/store unit between EX/MEM and MEM/WB. Non-memory
// instructions pass through with one cycle of latency; legal memory ops are
// handed to the memory controller and the pipeline is stalled until mct_ok
// or a timeout. Misaligned/illegal accesses and timeouts pulse err.
//
// Handshake: a request is presented to the controller by holding mct_e=1
// with mct_a/mct_cu/mct_wr/mct_n_i stable; the controller completes it with a
// single-cycle mct_ok pulse, after which mct_e drops. Dropping mct_e without
// a preceding mct_ok (timeout or reset) means the request was aborted.
// Upstream holds its inputs stable while stl=1.
module mm_lsu #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wn,
  input  logic            mem_v,
  input  logic            mem_wr,
  input  logic [1:0]      mem_sz,
  input  logic            mem_us,
  input  logic [XLEN-1:0] mem_n,
  output logic            we_o,
  output logic [RAW-1:0]  wa_o,
  output logic [XLEN-1:0] wn_o,
  output logic [XLEN-1:0] mct_a,
  output logic [XLEN-1:0] mct_n_i,
  input  logic [XLEN-1:0] mct_n_o,
  output logic            mct_wr,
  output logic            mct_e,
  output logic [1:0]      mct_cu,
  input  logic            mct_ok,
  output logic            stl,
  output logic            err
);
  import mm_lsu_pkg::*;

  localparam int TWC = $clog2(TMO + 1);
  localparam int TW  = (TWC < 1) ? 1 : TWC;
  localparam bit TMO_EN = (TMO != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? (TMO - 1) : 0);

  state_t state_q, state_d;
  logic [TW-1:0]  cnt_q;
  logic           we_l;
  logic [RAW-1:0] wa_l;
  logic           us_l;
  logic [XLEN-1:0] ext_data;

  // Decoded per-cycle actions from the FSM.
  logic pass, bad, start, count, done, tmo_fire, stl_raw;

  mm_ext #(.XLEN(XLEN)) u_ext (
    .din  (mct_n_o),
    .sz   (mct_cu),
    .us   (us_l),
    .dout (ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle action decode; completion takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    pass     = 1'b0;
    bad      = 1'b0;
    start    = 1'b0;
    count    = 1'b0;
    done     = 1'b0;
    tmo_fire = 1'b0;
    stl_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_v) begin
          pass = 1'b1;
        end else if (is_illegal(mem_sz, wn[1:0])) begin
          bad = 1'b1;
        end else begin
          start   = 1'b1;
          stl_raw = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mct_ok) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          count   = 1'b1;
          stl_raw = 1'b1;
          if (TMO_EN && (cnt_q == TMO_LAST)) begin
            tmo_fire = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is released at once while reset is held so upstream is never frozen by a dead request.
  assign stl = stl_raw & ~rst;

  // Datapath registers: writeback outputs, controller request and latched op context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_o    <= 1'b0;
      wa_o    <= '0;
      wn_o    <= '0;
      mct_a   <= '0;
      mct_n_i <= '0;
      mct_wr  <= 1'b0;
      mct_e   <= 1'b0;
      mct_cu  <= '0;
      err     <= 1'b0;
      cnt_q   <= '0;
      we_l    <= 1'b0;
      wa_l    <= '0;
      us_l    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (pass) begin
        we_o <= we;
        wa_o <= wa;
        wn_o <= wn;
      end
      if (bad) begin
        we_o <= 1'b0;
        err  <= 1'b1;
      end
      if (start) begin
        mct_a  <= wn;
        mct_cu <= mem_sz;
        mct_wr <= mem_wr;
        if (mem_wr) mct_n_i <= mem_n;
        mct_e  <= 1'b1;
        we_o   <= 1'b0;
        cnt_q  <= '0;
        we_l   <= we;
        wa_l   <= wa;
        us_l   <= mem_us;
      end
      if (count) cnt_q <= cnt_q + TW'(1);
      if (done) begin
        mct_e <= 1'b0;
        if (mct_wr) begin
          we_o <= 1'b0;
        end else begin
          we_o <= we_l;
          wa_o <= wa_l;
          wn_o <= ext_data;
        end
      end
      if (tmo_fire) begin
        mct_e <= 1'b0;
        we_o  <= 1'b0;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_lsu.sv
// Bench for mm_lsu (TMO=4): directed scenarios followed by a randomized mix
// of pass-through, loads, stores, illegal accesses and timeouts, checked
// against a behavioural model of the writeback and controller behaviour.
module tb_mm_lsu;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [RAW-1:0]  wa;
  logic [XLEN-1:0] wn;
  logic            mem_v;
  logic            mem_wr;
  logic [1:0]      mem_sz;
  logic            mem_us;
  logic [XLEN-1:0] mem_n;
  logic            we_o;
  logic [RAW-1:0]  wa_o;
  logic [XLEN-1:0] wn_o;
  logic [XLEN-1:0] mct_a;
  logic [XLEN-1:0] mct_n_i;
  logic [XLEN-1:0] mct_n_o;
  logic            mct_wr;
  logic            mct_e;
  logic [1:0]      mct_cu;
  logic            mct_ok;
  logic            stl;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  mm_lsu #(.XLEN(XLEN), .RAW(RAW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wn(wn),
    .mem_v(mem_v), .mem_wr(mem_wr), .mem_sz(mem_sz), .mem_us(mem_us), .mem_n(mem_n),
    .we_o(we_o), .wa_o(wa_o), .wn_o(wn_o),
    .mct_a(mct_a), .mct_n_i(mct_n_i), .mct_n_o(mct_n_o), .mct_wr(mct_wr),
    .mct_e(mct_e), .mct_cu(mct_cu), .mct_ok(mct_ok), .stl(stl), .err(err)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  // Reference extension computed arithmetically from the access size.
  function automatic logic [31:0] ext_ref(input logic [1:0] sz, input logic us, input logic [31:0] d);
    longint v;
    if (sz == 2'd0) begin
      v = d % 256;
      if (!us && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = d % 65536;
      if (!us && v >= 32768) v -= 65536;
    end else begin
      v = d;
    end
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legal memory op completed by mct_ok in BUSY cycle lat (1..TMO).
  task automatic do_mem(input logic wr, input logic [1:0] sz, input logic us,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic wen, input logic [4:0] wad,
                        input int lat, input logic [31:0] rdata);
    logic [31:0] e;
    mem_v = 1'b1; mem_wr = wr; mem_sz = sz; mem_us = us;
    wn = addr; mem_n = sdata; we = wen; wa = wad;
    #1 chk("req_stl", stl, 1);
    step();
    for (int k = 1; k <= lat; k++) begin
      chk("busy_e", mct_e, 1);
      chk("busy_a", mct_a, addr);
      chk("busy_cu", mct_cu, sz);
      chk("busy_wr", mct_wr, wr);
      if (wr) chk("busy_ni", mct_n_i, sdata);
      chk("busy_we", we_o, 0);
      chk("busy_err", err, 0);
      wn = $urandom;
      mem_n = $urandom;
      if (k < lat) begin
        #1 chk("busy_stl", stl, 1);
        step();
      end
    end
    mct_ok = 1'b1;
    mct_n_o = rdata;
    #1 chk("ok_stl", stl, 0);
    if (!wr) exp_q.push_back(ext_ref(sz, us, rdata));
    step();
    mct_ok = 1'b0; mem_v = 1'b0; we = 1'b0; mct_n_o = $urandom;
    chk("done_e", mct_e, 0);
    chk("done_err", err, 0);
    if (wr) begin
      chk("st_we", we_o, 0);
    end else begin
      e = exp_q.pop_front();
      chk("ld_we", we_o, wen);
      chk("ld_wa", wa_o, wad);
      chk("ld_wn", wn_o, e);
    end
  endtask

  task automatic do_bad(input logic [1:0] sz, input logic [31:0] addr);
    mem_v = 1'b1; mem_wr = $urandom_range(0, 1); mem_sz = sz; wn = addr; we = 1'b1;
    #1 chk("bad_stl", stl, 0);
    step();
    mem_v = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_e", mct_e, 0);
    chk("bad_we", we_o, 0);
    step();
    chk("bad_err_clr", err, 0);
  endtask

  task automatic do_tmo(input logic [31:0] addr);
    mem_v = 1'b1; mem_wr = 1'b0; mem_sz = 2'd3; mem_us = 1'b0; wn = addr; we = 1'b1;
    #1 chk("tmo_req_stl", stl, 1);
    step();
    for (int k = 1; k <= TMO; k++) begin
      chk("tmo_busy_e", mct_e, 1);
      chk("tmo_busy_err", err, 0);
      #1 chk("tmo_busy_stl", stl, 1);
      step();
    end
    mem_v = 1'b0; we = 1'b0;
    chk("tmo_e", mct_e, 0);
    chk("tmo_err", err, 1);
    chk("tmo_we", we_o, 0);
    step();
    chk("tmo_err_clr", err, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          bytes;
    int          kind;

    // Reset state.
    rst = 1'b1; we = 0; wa = 0; wn = 0; mem_v = 0; mem_wr = 0; mem_sz = 0;
    mem_us = 0; mem_n = 0; mct_n_o = 0; mct_ok = 0;
    step(); step();
    chk("rst_we", we_o, 0);
    chk("rst_wa", wa_o, 0);
    chk("rst_wn", wn_o, 0);
    chk("rst_e", mct_e, 0);
    chk("rst_a", mct_a, 0);
    chk("rst_err", err, 0);
    chk("rst_stl", stl, 0);
    rst = 1'b0;

    // Pass-through.
    we = 1'b1; wa = 5'd7; wn = 32'h1234;
    #1 chk("pt_stl", stl, 0);
    step();
    chk("pt_we", we_o, 1);
    chk("pt_wa", wa_o, 7);
    chk("pt_wn", wn_o, 32'h1234);
    chk("pt_stl2", stl, 0);

    // Signed byte load, unsigned half load, word store.
    do_mem(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 1'b1, 5'd3, 3, 32'h000000F0);
    do_mem(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b1, 5'd9, 2, 32'hABCD8001);
    do_mem(1'b1, 2'd3, 1'b0, 32'h200, 32'hDEADBEEF, 1'b1, 5'd1, 2, 32'h0);
    // Completion on the cycle the timeout would fire.
    do_mem(1'b0, 2'd3, 1'b1, 32'h304, 32'h0, 1'b1, 5'd31, TMO, 32'h87654321);

    // Illegal accesses.
    do_bad(2'd3, 32'h202);
    do_bad(2'd2, 32'h0);
    do_bad(2'd1, 32'h101);

    // Timeout.
    do_tmo(32'h400);

    // Reset in the second BUSY cycle.
    mem_v = 1'b1; mem_wr = 1'b0; mem_sz = 2'd3; wn = 32'h500; we = 1'b1; wa = 5'd2;
    step(); step();
    chk("pre_rst_e", mct_e, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_e", mct_e, 0);
    chk("rst_mid_stl", stl, 0);
    step();
    rst = 1'b0; mem_v = 1'b0; we = 1'b1; wa = 5'd4; wn = 32'h55;
    #1 chk("post_rst_stl", stl, 0);
    step();
    chk("post_rst_we", we_o, 1);
    chk("post_rst_wn", wn_o, 32'h55);
    chk("post_rst_e", mct_e, 0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0:       sz = 2'd0;
        1:       sz = 2'd1;
        default: sz = 2'd3;
      endcase
      bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      addr = $urandom;
      addr = addr - (addr % bytes);
      if (kind == 0) begin
        we = $urandom_range(0, 1); wa = $urandom; wn = $urandom; mem_v = 1'b0;
        #1 chk("rpt_stl", stl, 0);
        step();
        chk("rpt_we", we_o, we);
        chk("rpt_wa", wa_o, wa);
        chk("rpt_wn", wn_o, wn);
      end else if (kind == 1 || kind == 2) begin
        do_mem(kind == 2, sz, $urandom_range(0, 1), addr, $urandom,
               $urandom_range(0, 1), $urandom, $urandom_range(1, TMO), $urandom);
      end else if (kind == 3) begin
        if (sz == 2'd0) do_bad(2'd2, addr);
        else            do_bad(sz, addr + 1);
      end else begin
        do_tmo(addr - (addr % 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
